doorlock_ctrl: RTL and testbench
================================

// Module: doorlock_ctrl
// PURPOSE
//  Parametrised doorlock controller: N-digit code entry/verify, in-session code reprogramming, failed-attempt lockout, open/entry timeouts.
//  Sits after edge_detector/debouncor (takes clean one-cycle pulses); drives fnd digit decoders and LEDs in top.
// PARAMETERS
//  NUM_DIGITS    3          code length in BCD digits (1..8)
//  MAX_FAIL      3          consecutive failed verifies that trigger LOCKOUT (>=1)
//  OPEN_CYCLES   50000000   cycles OPEN is held before auto-relock
//  LOCK_CYCLES   250000000  cycles LOCKOUT lasts
//  ENTRY_CYCLES  250000000  idle cycles (no digit) in ENTRY/PROG before abort
//  DEFAULT_PSWD  12'h123    code loaded at reset, width 4*NUM_DIGITS, digit0 in [3:0]
// PORTS
//  clk          in   1              system clock
//  rst_n        in   1              synchronous active-low reset
//  mode_ctrl    in   1              1 = request reprogram (sampled only on btn_start in OPEN)
//  digit_valid  in   1              one-cycle pulse: digit_val is a key press
//  digit_val    in   4              BCD digit; values >9 ignored
//  btn_start    in   1              one-cycle pulse, start session
//  btn_end      in   1              one-cycle pulse, submit / close
//  disp_digits  out  4*NUM_DIGITS   entered digits, newest in [3:0], 4'hF = blank
//  disp_status  out  4              F idle, E entry, A open, B prog, C lockout
//  unlocked     out  1              high in OPEN
//  locked_out   out  1              high in LOCKOUT
//  fail_pulse   out  1              one cycle per failed verify
//  prog_done    out  1              one cycle when new code stored
//  fail_cnt     out  $clog2(MAX_FAIL+1)  consecutive failures
//  state_led    out  6              one-hot: {LOCKOUT,PROG,OPEN,ENTRY,IDLE,reserved=0}
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, code=DEFAULT_PSWD, disp_digits all 4'hF, disp_status F, all flags/pulses 0, fail_cnt 0, timers 0.
//  All outputs registered. Submit latency: btn_end at edge N -> new state/pulses visible after edge N+1.
//  IDLE: btn_start -> ENTRY, buffer cleared (all F), cnt=0. digit_valid/btn_end ignored.
//  ENTRY: valid digit (<=9) shifts buffer left 4 bits, inserts at [3:0], cnt++; when cnt==NUM_DIGITS further digits ignored.
//   btn_end: cnt==NUM_DIGITS and buffer==code -> OPEN, fail_cnt=0; else fail_pulse, fail_cnt++;
//   if fail_cnt reaches MAX_FAIL -> LOCKOUT, else -> IDLE.
//   btn_start in ENTRY: restart (buffer cleared, cnt=0, stays ENTRY, no fail).
//   ENTRY_CYCLES with no valid digit -> IDLE, no fail counted.
//  OPEN: unlocked=1, timer counts OPEN_CYCLES then -> IDLE. btn_end -> IDLE immediately.
//   btn_start with mode_ctrl=1 -> PROG (buffer cleared); with mode_ctrl=0 ignored.
//  PROG: digit entry identical to ENTRY. btn_end with cnt==NUM_DIGITS -> code<=buffer, prog_done, -> IDLE.
//   btn_end with cnt<NUM_DIGITS -> OPEN (timer restarted), code unchanged, no pulse. Timeout -> IDLE, code unchanged.
//  LOCKOUT: locked_out=1, all inputs ignored; after LOCK_CYCLES -> IDLE, fail_cnt=0.
//  Simultaneous: btn_end beats digit_valid (digit dropped, compare uses buffer before that digit);
//   btn_start beats btn_end if both high the same cycle.
//  disp_digits blank in IDLE and LOCKOUT; holds buffer in ENTRY/PROG; all F in OPEN.
//  Timers: width $clog2(max cycle param+1), clear on every state change, saturate never (exit exactly at count).
//  mode_ctrl changes outside the OPEN btn_start sample have no effect. Reset mid-any-state: immediate reset values next edge.
// TESTING (NUM_DIGITS=3, MAX_FAIL=3, OPEN=8, LOCK=16, ENTRY=20, DEFAULT=12'h123)
//  1 Reset; start,1,2,3,end -> unlocked=1 and status A one edge after end; IDLE exactly 8 cycles later.
//  2 Three sessions 1,2,4,end -> fail_pulse x3, fail_cnt 1,2 then LOCKOUT; btn_start ignored 16 cycles; IDLE, fail_cnt 0.
//  3 Unlock, mode_ctrl=1 start, 7,8,9,end -> prog_done; then 1,2,3 fails, 7,8,9 opens; PROG with 7,8,end -> back to OPEN, code unchanged.
//  4 Entry 1,2,3,4 -> disp_digits 12'h123 (4th dropped); digit_val=4'hC ignored; 1,2 + end -> fail_pulse.
//  5 digit 3 and btn_end same cycle after 1,2 -> fail (cnt 2); start+end same cycle in ENTRY -> restart, no fail.
//  6 Entry idle 20 cycles -> IDLE, fail_cnt unchanged; rst_n=0 mid-LOCKOUT -> IDLE, code=12'h123, fail_cnt 0.

Source files
------------

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl
//   Keypad door lock controller. Collects NUM_DIGITS BCD digits, compares them
//   with the stored code, opens the lock for OPEN_CYCLES, and lets the user
//   store a new code while the door is open. MAX_FAIL consecutive wrong codes
//   lock the keypad out for LOCK_CYCLES. A session with no key presses is
//   abandoned after ENTRY_CYCLES.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   mode_ctrl    1 = request reprogram (only looked at on btn_start in OPEN)
//   digit_valid  one-cycle pulse, digit_val holds a key press
//   digit_val    BCD digit, values above 9 are ignored
//   btn_start    one-cycle pulse, start / restart a session
//   btn_end      one-cycle pulse, submit / close
//   disp_digits  entered digits, newest in [3:0], 4'hF = blank
//   disp_status  F idle, E entry, A open, B prog, C lockout
//   unlocked     high while OPEN
//   locked_out   high while LOCKOUT
//   fail_pulse   one cycle per failed verify
//   prog_done    one cycle when a new code is stored
//   fail_cnt     consecutive failed verifies
//   state_led    one-hot {LOCKOUT,PROG,OPEN,ENTRY,IDLE,0}
module doorlock_ctrl #(
  parameter int NUM_DIGITS   = 3,
  parameter int MAX_FAIL     = 3,
  parameter int OPEN_CYCLES  = 50000000,
  parameter int LOCK_CYCLES  = 250000000,
  parameter int ENTRY_CYCLES = 250000000,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PSWD = 12'h123
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mode_ctrl,
  input  logic                            digit_valid,
  input  logic [3:0]                      digit_val,
  input  logic                            btn_start,
  input  logic                            btn_end,
  output logic [4*NUM_DIGITS-1:0]         disp_digits,
  output logic [3:0]                      disp_status,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic                            fail_pulse,
  output logic                            prog_done,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [5:0]                      state_led
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int MAX_AB  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int MAX_CYC = (MAX_AB > ENTRY_CYCLES) ? MAX_AB : ENTRY_CYCLES;
  localparam int TW = $clog2(MAX_CYC + 1);

  // Timers run from 0, so the last cycle of a timed state sees CYCLES-1.
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(NUM_DIGITS);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
  localparam logic [DW-1:0] BLANK      = {DW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   buffer, buffer_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [DW-1:0]   code, code_d;
  logic [FW-1:0]   fail_cnt_d;
  logic [TW-1:0]   timer, timer_d;
  logic            fail_evt, prog_evt;

  logic [DW-1:0]   disp_d;
  logic [3:0]      status_d;
  logic            unlocked_d, locked_d;
  logic [5:0]      led_d;

  logic            digit_ok, full;
  logic [DW+3:0]   shifted;

  assign digit_ok = digit_valid && (digit_val <= 4'd9);
  assign full     = (cnt == CNT_FULL);
  // Appending the digit below the buffer and keeping the low DW bits drops the
  // oldest digit; this form also works for a single-digit code.
  assign shifted  = {buffer, digit_val};

  // State and output registers. Outputs are loaded from the next-state
  // decode so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      buffer      <= BLANK;
      cnt         <= '0;
      code        <= DEFAULT_PSWD;
      fail_cnt    <= '0;
      timer       <= '0;
      disp_digits <= BLANK;
      disp_status <= 4'hF;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      fail_pulse  <= 1'b0;
      prog_done   <= 1'b0;
      state_led   <= 6'b000010;
    end else begin
      state       <= state_d;
      buffer      <= buffer_d;
      cnt         <= cnt_d;
      code        <= code_d;
      fail_cnt    <= fail_cnt_d;
      timer       <= timer_d;
      disp_digits <= disp_d;
      disp_status <= status_d;
      unlocked    <= unlocked_d;
      locked_out  <= locked_d;
      fail_pulse  <= fail_evt;
      prog_done   <= prog_evt;
      state_led   <= led_d;
    end
  end

  // Next-state logic. Priority inside a session: btn_start, then btn_end,
  // then a digit, then the idle timeout.
  always_comb begin
    state_d    = state;
    buffer_d   = buffer;
    cnt_d      = cnt;
    code_d     = code;
    fail_cnt_d = fail_cnt;
    timer_d    = timer + TW'(1);
    fail_evt   = 1'b0;
    prog_evt   = 1'b0;

    case (state)
      S_IDLE: begin
        timer_d = '0;
        if (btn_start) begin
          state_d  = S_ENTRY;
          buffer_d = BLANK;
          cnt_d    = '0;
        end
      end

      S_ENTRY, S_PROG: begin
        if (btn_start) begin
          buffer_d = BLANK;
          cnt_d    = '0;
          timer_d  = '0;
        end else if (btn_end) begin
          if (state == S_ENTRY) begin
            if (full && (buffer == code)) begin
              state_d    = S_OPEN;
              fail_cnt_d = '0;
            end else begin
              fail_evt   = 1'b1;
              fail_cnt_d = fail_cnt + FW'(1);
              state_d    = (fail_cnt == FAIL_LAST) ? S_LOCKOUT : S_IDLE;
            end
          end else if (full) begin
            code_d   = buffer;
            prog_evt = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_OPEN;
          end
        end else if (digit_ok) begin
          timer_d = '0;
          if (!full) begin
            buffer_d = shifted[DW-1:0];
            cnt_d    = cnt + CW'(1);
          end
        end else if (timer == ENTRY_LAST) begin
          state_d = S_IDLE;
        end
      end

      S_OPEN: begin
        if (btn_start && mode_ctrl) begin
          state_d  = S_PROG;
          buffer_d = BLANK;
          cnt_d    = '0;
        end else if (btn_end) begin
          state_d = S_IDLE;
        end else if (timer == OPEN_LAST) begin
          state_d = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state) begin
      timer_d = '0;
    end
  end

  // Output decode from the upcoming state and buffer.
  always_comb begin
    disp_d     = BLANK;
    status_d   = 4'hF;
    unlocked_d = 1'b0;
    locked_d   = 1'b0;
    led_d      = 6'b000010;
    case (state_d)
      S_ENTRY: begin
        disp_d   = buffer_d;
        status_d = 4'hE;
        led_d    = 6'b000100;
      end
      S_OPEN: begin
        status_d   = 4'hA;
        unlocked_d = 1'b1;
        led_d      = 6'b001000;
      end
      S_PROG: begin
        disp_d   = buffer_d;
        status_d = 4'hB;
        led_d    = 6'b010000;
      end
      S_LOCKOUT: begin
        status_d = 4'hC;
        locked_d = 1'b1;
        led_d    = 6'b100000;
      end
      default: begin
        led_d = 6'b000010;
      end
    endcase
  end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl
//   Directed bench for doorlock_ctrl with 3 digits, 3 failures to lockout,
//   OPEN 8 cycles, LOCKOUT 16 cycles, ENTRY timeout 20 cycles, code 12'h123.
//   Inputs change 1 ns after a rising edge; outputs are read at that point.
module tb_doorlock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_ctrl;
  logic        digit_valid;
  logic [3:0]  digit_val;
  logic        btn_start;
  logic        btn_end;
  logic [11:0] disp_digits;
  logic [3:0]  disp_status;
  logic        unlocked;
  logic        locked_out;
  logic        fail_pulse;
  logic        prog_done;
  logic [1:0]  fail_cnt;
  logic [5:0]  state_led;

  int checks = 0;
  int errors = 0;

  doorlock_ctrl #(
    .NUM_DIGITS   (3),
    .MAX_FAIL     (3),
    .OPEN_CYCLES  (8),
    .LOCK_CYCLES  (16),
    .ENTRY_CYCLES (20),
    .DEFAULT_PSWD (12'h123)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_ctrl   (mode_ctrl),
    .digit_valid (digit_valid),
    .digit_val   (digit_val),
    .btn_start   (btn_start),
    .btn_end     (btn_end),
    .disp_digits (disp_digits),
    .disp_status (disp_status),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_pulse  (fail_pulse),
    .prog_done   (prog_done),
    .fail_cnt    (fail_cnt),
    .state_led   (state_led)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_val   = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic do_start();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
  endtask

  task automatic do_end();
    btn_end = 1'b1;
    tick();
    btn_end = 1'b0;
  endtask

  task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    do_start();
    press(a);
    press(b);
    press(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (disp_status !== 4'hF) begin errors++; $display("[TB] FAIL reset_status got %h want F", disp_status); end
    checks++; if (disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_disp got %h want FFF", disp_digits); end
    checks++; if (unlocked !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b want 00", unlocked, locked_out); end
    checks++; if (fail_pulse !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b%b want 00", fail_pulse, prog_done); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_fail_cnt got %0d want 0", fail_cnt); end
    checks++; if (state_led !== 6'b000010) begin errors++; $display("[TB] FAIL reset_led got %b want 000010", state_led); end
    rst_n = 1'b1;
  endtask

  task automatic test_unlock();
    do_start();
    checks++; if (disp_status !== 4'hE || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL start_entry got %h/%h want E/FFF", disp_status, disp_digits); end
    press(4'd1);
    press(4'd2);
    press(4'd3);
    checks++; if (disp_digits !== 12'h123) begin errors++; $display("[TB] FAIL entry_disp got %h want 123", disp_digits); end
    do_end();
    checks++; if (unlocked !== 1'b1 || disp_status !== 4'hA) begin errors++; $display("[TB] FAIL unlock got %b/%h want 1/A", unlocked, disp_status); end
    checks++; if (state_led !== 6'b001000 || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL open_led_disp got %b/%h want 001000/FFF", state_led, disp_digits); end
    checks++; if (fail_cnt !== 2'd0 || fail_pulse !== 1'b0) begin errors++; $display("[TB] FAIL open_fail got %0d/%b want 0/0", fail_cnt, fail_pulse); end
    repeat (7) tick();
    checks++; if (unlocked !== 1'b1) begin errors++; $display("[TB] FAIL open_hold7 got %b want 1", unlocked); end
    tick();
    checks++; if (unlocked !== 1'b0 || disp_status !== 4'hF) begin errors++; $display("[TB] FAIL open_timeout got %b/%h want 0/F", unlocked, disp_status); end
  endtask

  task automatic test_lockout();
    for (int s = 1; s <= 3; s++) begin
      logic [1:0] exp_cnt;
      exp_cnt = 2'(s);
      enter3(4'd1, 4'd2, 4'd4);
      do_end();
      checks++; if (fail_pulse !== 1'b1) begin errors++; $display("[TB] FAIL bad_code_pulse%0d got %b want 1", s, fail_pulse); end
      checks++; if (fail_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL bad_code_cnt%0d got %0d want %0d", s, fail_cnt, exp_cnt); end
      if (s < 3) begin
        checks++; if (disp_status !== 4'hF || locked_out !== 1'b0) begin errors++; $display("[TB] FAIL bad_code_idle%0d got %h/%b want F/0", s, disp_status, locked_out); end
      end else begin
        checks++; if (disp_status !== 4'hC || locked_out !== 1'b1 || state_led !== 6'b100000) begin errors++; $display("[TB] FAIL lockout_enter got %h/%b/%b want C/1/100000", disp_status, locked_out, state_led); end
      end
    end
    btn_start   = 1'b1;
    digit_val   = 4'd1;
    digit_valid = 1'b1;
    repeat (15) tick();
    btn_start   = 1'b0;
    digit_valid = 1'b0;
    checks++; if (locked_out !== 1'b1 || fail_pulse !== 1'b0 || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL lockout_hold got %b/%b/%h want 1/0/FFF", locked_out, fail_pulse, disp_digits); end
    tick();
    checks++; if (locked_out !== 1'b0 || disp_status !== 4'hF) begin errors++; $display("[TB] FAIL lockout_exit got %b/%h want 0/F", locked_out, disp_status); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("[TB] FAIL lockout_clear_cnt got %0d want 0", fail_cnt); end
  endtask

  task automatic test_prog();
    enter3(4'd1, 4'd2, 4'd3);
    do_end();
    mode_ctrl = 1'b0;
    do_start();
    checks++; if (disp_status !== 4'hA) begin errors++; $display("[TB] FAIL open_start_mode0 got %h want A", disp_status); end
    mode_ctrl = 1'b1;
    do_start();
    checks++; if (disp_status !== 4'hB || state_led !== 6'b010000 || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL prog_enter got %h/%b/%h want B/010000/FFF", disp_status, state_led, disp_digits); end
    mode_ctrl = 1'b0;
    press(4'd7);
    press(4'd8);
    press(4'd9);
    checks++; if (disp_digits !== 12'h789) begin errors++; $display("[TB] FAIL prog_disp got %h want 789", disp_digits); end
    do_end();
    checks++; if (prog_done !== 1'b1 || disp_status !== 4'hF) begin errors++; $display("[TB] FAIL prog_store got %b/%h want 1/F", prog_done, disp_status); end
    tick();
    checks++; if (prog_done !== 1'b0) begin errors++; $display("[TB] FAIL prog_done_width got %b want 0", prog_done); end
    enter3(4'd1, 4'd2, 4'd3);
    do_end();
    checks++; if (fail_pulse !== 1'b1 || fail_cnt !== 2'd1 || unlocked !== 1'b0) begin errors++; $display("[TB] FAIL old_code_rejected got %b/%0d/%b want 1/1/0", fail_pulse, fail_cnt, unlocked); end
    enter3(4'd7, 4'd8, 4'd9);
    do_end();
    checks++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin errors++; $display("[TB] FAIL new_code_opens got %b/%0d want 1/0", unlocked, fail_cnt); end
    mode_ctrl = 1'b1;
    do_start();
    mode_ctrl = 1'b0;
    press(4'd7);
    press(4'd8);
    do_end();
    checks++; if (disp_status !== 4'hA || unlocked !== 1'b1 || prog_done !== 1'b0) begin errors++; $display("[TB] FAIL prog_short_back_open got %h/%b/%b want A/1/0", disp_status, unlocked, prog_done); end
    repeat (7) tick();
    checks++; if (unlocked !== 1'b1) begin errors++; $display("[TB] FAIL reopen_timer_restart got %b want 1", unlocked); end
    do_end();
    checks++; if (unlocked !== 1'b0 || disp_status !== 4'hF) begin errors++; $display("[TB] FAIL open_btn_end got %b/%h want 0/F", unlocked, disp_status); end
    enter3(4'd7, 4'd8, 4'd9);
    do_end();
    checks++; if (unlocked !== 1'b1) begin errors++; $display("[TB] FAIL code_unchanged got %b want 1", unlocked); end
    do_end();
  endtask

  task automatic test_entry_filter();
    do_start();
    press(4'hC);
    checks++; if (disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL non_bcd_ignored got %h want FFF", disp_digits); end
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    checks++; if (disp_digits !== 12'h123) begin errors++; $display("[TB] FAIL fourth_digit_dropped got %h want 123", disp_digits); end
    do_start();
    press(4'd1);
    press(4'd2);
    checks++; if (disp_digits !== 12'hF12) begin errors++; $display("[TB] FAIL partial_disp got %h want F12", disp_digits); end
    do_end();
    checks++; if (fail_pulse !== 1'b1 || fail_cnt !== 2'd1 || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL short_code_fail got %b/%0d/%h want 1/1/FFF", fail_pulse, fail_cnt, disp_digits); end
  endtask

  task automatic test_simultaneous();
    do_start();
    press(4'd1);
    press(4'd2);
    digit_val   = 4'd3;
    digit_valid = 1'b1;
    btn_end     = 1'b1;
    tick();
    digit_valid = 1'b0;
    btn_end     = 1'b0;
    checks++; if (fail_pulse !== 1'b1 || fail_cnt !== 2'd2 || disp_status !== 4'hF) begin errors++; $display("[TB] FAIL end_beats_digit got %b/%0d/%h want 1/2/F", fail_pulse, fail_cnt, disp_status); end
    do_start();
    press(4'd1);
    btn_start = 1'b1;
    btn_end   = 1'b1;
    tick();
    btn_start = 1'b0;
    btn_end   = 1'b0;
    checks++; if (disp_status !== 4'hE || disp_digits !== 12'hFFF) begin errors++; $display("[TB] FAIL start_beats_end got %h/%h want E/FFF", disp_status, disp_digits); end
    checks++; if (fail_pulse !== 1'b0 || fail_cnt !== 2'd2) begin errors++; $display("[TB] FAIL restart_no_fail got %b/%0d want 0/2", fail_pulse, fail_cnt); end
  endtask

  task automatic test_timeout_and_reset();
    repeat (19) tick();
    checks++; if (disp_status !== 4'hE) begin errors++; $display("[TB] FAIL entry_hold19 got %h want E", disp_status); end
    tick();
    checks++; if (disp_status !== 4'hF || fail_cnt !== 2'd2 || fail_pulse !== 1'b0) begin errors++; $display("[TB] FAIL entry_timeout got %h/%0d/%b want F/2/0", disp_status, fail_cnt, fail_pulse); end
    do_start();
    press(4'd1);
    do_end();
    checks++; if (locked_out !== 1'b1 || fail_cnt !== 2'd3) begin errors++; $display("[TB] FAIL third_fail_lock got %b/%0d want 1/3", locked_out, fail_cnt); end
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (locked_out !== 1'b0 || disp_status !== 4'hF || fail_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_mid_lockout got %b/%h/%0d want 0/F/0", locked_out, disp_status, fail_cnt); end
    enter3(4'd1, 4'd2, 4'd3);
    do_end();
    checks++; if (unlocked !== 1'b1) begin errors++; $display("[TB] FAIL default_code_restored got %b want 1", unlocked); end
  endtask

  initial begin
    rst_n       = 1'b0;
    mode_ctrl   = 1'b0;
    digit_valid = 1'b0;
    digit_val   = 4'd0;
    btn_start   = 1'b0;
    btn_end     = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_prog();
    test_entry_filter();
    test_simultaneous();
    test_timeout_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
